// File: rtl/program_loader.sv
// program_loader: assembles big-endian 32-bit words from a byte stream and writes them into instruction memory
//
// Ports:
//   clk, reset        system clock and synchronous active-high reset
//   Start, WordCount  begin a load of WordCount words (clamped to MEMORY_DEPTH)
//   ByteIn, ByteValid, ByteReady   byte stream handshake (transfer when valid && ready)
//   WriteEnable, WriteAddress, WriteData   instruction memory write port
//   Busy, CpuHold     load in progress (CPU held off)
//   Done              one-cycle end-of-load pulse
//   Error             checksum mismatch, sticky until next Start or reset
//
// Build option: define PROGRAM_LOADER_CHECKSUM_EN to read and verify a trailing
// mod-256 checksum byte after the last word; otherwise Error is tied low.
module program_loader #(
   parameter int MEMORY_DEPTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start,
   input  logic [15:0]           WordCount,
   input  logic [7:0]            ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  WriteEnable,
   output logic [DATA_WIDTH-1:0] WriteAddress,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  Busy,
   output logic                  CpuHold,
   output logic                  Done,
   output logic                  Error
);
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
   localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam state_t LAST = CHECK;
`else
   localparam state_t LAST = DONE;
`endif
   state_t state_q, state_d;
   logic [15:0] n_q, cnt_q, n_clamp;
   logic [1:0] byte_q;
   logic [DATA_WIDTH-1:0] shift_q, addr_q, waddr_q, wdata_q, word;
   logic start_ok, hs;
   assign n_clamp = (WordCount > DEPTH16) ? DEPTH16 : WordCount;
   assign start_ok = (state_q == IDLE) && Start;
   assign hs = ByteValid && ByteReady;
   // word as it will stand once the current byte has been shifted in
   assign word = {shift_q[DATA_WIDTH-9:0], ByteIn};
   assign WriteAddress = waddr_q;
   assign WriteData = wdata_q;
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Start) state_d = (n_clamp == 16'd0) ? DONE : RECV;
         RECV:    if (hs && byte_q == 2'd3) state_d = WRITE;
         WRITE:   state_d = (cnt_q + 16'd1 == n_q) ? LAST : RECV;
         CHECK:   if (ByteValid) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      ByteReady = (state_q == RECV) || (state_q == CHECK);
      WriteEnable = state_q == WRITE;
      Done = state_q == DONE;
      Busy = state_q != IDLE;
      CpuHold = Busy;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q <= '0;
         cnt_q <= '0;
         byte_q <= '0;
         shift_q <= '0;
         addr_q <= BASE_ADDRESS;
         waddr_q <= BASE_ADDRESS;
         wdata_q <= '0;
      end else begin
         if (start_ok) begin
            n_q <= n_clamp;
            cnt_q <= '0;
            byte_q <= '0;
            addr_q <= BASE_ADDRESS;
            waddr_q <= BASE_ADDRESS;
         end
         if (state_q == RECV && hs) begin
            shift_q <= word;
            byte_q <= byte_q + 2'd1;
            if (byte_q == 2'd3) begin
               wdata_q <= word;
               waddr_q <= addr_q;
            end
         end
         if (state_q == WRITE) begin
            addr_q <= addr_q + DATA_WIDTH'(4);
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] sum_q;
   logic err_q;
   assign Error = err_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (start_ok) begin
            sum_q <= '0;
            err_q <= 1'b0;
         end
         if (state_q == RECV && hs) sum_q <= sum_q + ByteIn;
         if (state_q == CHECK && ByteValid) err_q <= ByteIn != sum_q;
      end
   end
`else
   assign Error = 1'b0;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader
module tb_program_loader;
   localparam logic [31:0] BASE = 32'h0040_0000;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic Start = 1'b0;
   logic [15:0] WordCount = '0;
   logic [7:0] ByteIn = '0;
   logic ByteValid = 1'b0;
   logic ByteReady, WriteEnable, Busy, CpuHold, Done, Error;
   logic [31:0] WriteAddress, WriteData;
   int vectors = 0;
   int miscompares = 0;
   logic [7:0] src[$];
   logic [31:0] wa[$], wd[$];
   int idx, done_cnt, done_at, rdy_seen, rdy_we;
   logic busy_first;

   always #5 clk = ~clk;

   program_loader dut (
      .clk(clk), .reset(reset), .Start(Start), .WordCount(WordCount),
      .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
      .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
      .Busy(Busy), .CpuHold(CpuHold), .Done(Done), .Error(Error)
   );

   // runs one load from src[], recording every write and handshake; bounded by limit cycles
   task automatic load(input logic [15:0] wc, input bit toggle, input int restart_cyc, input int limit);
      int cyc, since;
      bit v, hs;
      wa.delete(); wd.delete();
      idx = 0; done_cnt = 0; done_at = -1; rdy_seen = 0; rdy_we = 0;
      Start = 1'b1; WordCount = wc;
      @(posedge clk); #1;
      Start = 1'b0;
      busy_first = Busy;
      cyc = 0; since = 0;
      while (cyc < limit && !(done_cnt > 0 && since >= 2)) begin
         if (WriteEnable) begin
            wa.push_back(WriteAddress);
            wd.push_back(WriteData);
            if (ByteReady) rdy_we++;
         end
         if (ByteReady) rdy_seen = 1;
         if (Done) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
         end
         if (done_cnt > 0) since++;
         Start = (cyc == restart_cyc);
         if (cyc == restart_cyc) WordCount = 16'd5;
         v = idx < src.size() && (!toggle || cyc % 2 == 0);
         ByteValid = v;
         ByteIn = v ? src[idx] : 8'h00;
         hs = v && ByteReady;
         @(posedge clk); #1;
         if (hs) idx++;
         cyc++;
      end
      Start = 1'b0;
      ByteValid = 1'b0;
   endtask

   task automatic test_reset();
      vectors++; if ({ByteReady, WriteEnable, Busy, CpuHold, Done, Error} !== 6'b0) begin miscompares++; $display("FAIL reset_flags: got %b expected 000000", {ByteReady, WriteEnable, Busy, CpuHold, Done, Error}); end
      vectors++; if (WriteAddress !== BASE) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", WriteAddress, BASE); end
      vectors++; if (WriteData !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 00000000", WriteData); end
   endtask

   task automatic test_basic(input bit toggle);
      src = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      src.push_back(8'h39);
`endif
      load(16'd2, toggle, -1, 100);
      vectors++; if (busy_first !== 1'b1) begin miscompares++; $display("FAIL busy_after_start t%0d: got %b expected 1", toggle, busy_first); end
      vectors++; if (wa.size() !== 2) begin miscompares++; $display("FAIL write_count t%0d: got %0d expected 2", toggle, wa.size()); end
      if (wa.size() == 2) begin
         vectors++; if (wa[0] !== 32'h0040_0000 || wd[0] !== 32'h2008_0005) begin miscompares++; $display("FAIL write0 t%0d: got %h/%h expected 00400000/20080005", toggle, wa[0], wd[0]); end
         vectors++; if (wa[1] !== 32'h0040_0004 || wd[1] !== 32'h0000_000C) begin miscompares++; $display("FAIL write1 t%0d: got %h/%h expected 00400004/0000000c", toggle, wa[1], wd[1]); end
      end
      vectors++; if (idx !== src.size()) begin miscompares++; $display("FAIL bytes_consumed t%0d: got %0d expected %0d", toggle, idx, src.size()); end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL done_pulses t%0d: got %0d expected 1", toggle, done_cnt); end
      vectors++; if (rdy_we !== 0) begin miscompares++; $display("FAIL ready_in_write t%0d: got %0d expected 0", toggle, rdy_we); end
      vectors++; if (Busy !== 1'b0 || CpuHold !== 1'b0) begin miscompares++; $display("FAIL busy_end t%0d: got %b%b expected 00", toggle, Busy, CpuHold); end
      vectors++; if (Error !== 1'b0) begin miscompares++; $display("FAIL error_basic t%0d: got %b expected 0", toggle, Error); end
   endtask

   task automatic test_zero();
      src = '{8'h55, 8'h66};
      load(16'd0, 1'b0, -1, 20);
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
      vectors++; if (done_at < 0 || done_at > 1) begin miscompares++; $display("FAIL zero_latency: got %0d expected 0..1", done_at); end
      vectors++; if (wa.size() !== 0) begin miscompares++; $display("FAIL zero_writes: got %0d expected 0", wa.size()); end
      vectors++; if (rdy_seen !== 0 || idx !== 0) begin miscompares++; $display("FAIL zero_ready: got %0d/%0d expected 0/0", rdy_seen, idx); end
   endtask

   task automatic test_clamp();
      src.delete();
      for (int i = 0; i < 160; i++) src.push_back(8'(i));
      load(16'd40, 1'b0, -1, 400);
      vectors++; if (wa.size() !== 32) begin miscompares++; $display("FAIL clamp_writes: got %0d expected 32", wa.size()); end
      if (wa.size() == 32) begin
         vectors++; if (wa[31] !== 32'h0040_007C || wd[31] !== 32'h7C7D_7E7F) begin miscompares++; $display("FAIL clamp_last: got %h/%h expected 0040007c/7c7d7e7f", wa[31], wd[31]); end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      vectors++; if (idx !== 129) begin miscompares++; $display("FAIL clamp_consumed: got %0d expected 129", idx); end
`else
      vectors++; if (idx !== 128) begin miscompares++; $display("FAIL clamp_consumed: got %0d expected 128", idx); end
`endif
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL clamp_done: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_reset_abort();
      Start = 1'b1; WordCount = 16'd2;
      @(posedge clk); #1;
      Start = 1'b0; ByteValid = 1'b1; ByteIn = 8'h11;
      @(posedge clk); #1;
      ByteIn = 8'h22;
      @(posedge clk); #1;
      ByteValid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++; if ({WriteEnable, Busy, ByteReady, Done} !== 4'b0) begin miscompares++; $display("FAIL abort_flags: got %b expected 0000", {WriteEnable, Busy, ByteReady, Done}); end
      @(posedge clk); #1;
      vectors++; if ({WriteEnable, Done} !== 2'b0) begin miscompares++; $display("FAIL abort_quiet: got %b expected 00", {WriteEnable, Done}); end
      src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      src.push_back(8'h0E);
`endif
      load(16'd1, 1'b0, -1, 50);
      vectors++; if (wa.size() !== 1) begin miscompares++; $display("FAIL abort_writes: got %0d expected 1", wa.size()); end
      if (wa.size() == 1) begin
         vectors++; if (wa[0] !== BASE || wd[0] !== 32'hAABB_CCDD) begin miscompares++; $display("FAIL abort_word: got %h/%h expected 00400000/aabbccdd", wa[0], wd[0]); end
      end
   endtask

   task automatic test_start_while_busy();
      src = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      src.push_back(8'hAA);
`endif
      load(16'd1, 1'b0, 2, 50);
      vectors++; if (wa.size() !== 1) begin miscompares++; $display("FAIL busy_start_writes: got %0d expected 1", wa.size()); end
      vectors++; if (done_cnt !== 1 || Busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_done: got %0d/%b expected 1/0", done_cnt, Busy); end
   endtask

   task automatic test_checksum();
      src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      load(16'd1, 1'b0, -1, 50);
      vectors++; if (wa.size() !== 1 || wd[0] !== 32'h0102_0304) begin miscompares++; $display("FAIL csum_word: got %0d writes expected 1 of 01020304", wa.size()); end
      vectors++; if (Error !== 1'b0 || done_cnt !== 1) begin miscompares++; $display("FAIL csum_good: got %b/%0d expected 0/1", Error, done_cnt); end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      vectors++; if (idx !== 5) begin miscompares++; $display("FAIL csum_consumed: got %0d expected 5", idx); end
      src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
      load(16'd1, 1'b0, -1, 50);
      vectors++; if (Error !== 1'b1 || done_cnt !== 1) begin miscompares++; $display("FAIL csum_bad: got %b/%0d expected 1/1", Error, done_cnt); end
      vectors++; if (CpuHold !== 1'b0) begin miscompares++; $display("FAIL csum_hold: got %b expected 0", CpuHold); end
      src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      load(16'd1, 1'b0, -1, 50);
      vectors++; if (Error !== 1'b0) begin miscompares++; $display("FAIL csum_clear: got %b expected 0", Error); end
`else
      vectors++; if (idx !== 4) begin miscompares++; $display("FAIL csum_consumed: got %0d expected 4", idx); end
`endif
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_basic(1'b0);
      test_basic(1'b1);
      test_zero();
      test_clamp();
      test_reset_abort();
      test_start_while_busy();
      test_checksum();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
